eth_vlg_tx_sched: RTL and testbench

//  Round-robin scheduler sharing the single TX MAC stream among N protocol sources (ARP, ICMP, UDP, TCP, ...).

---
 rtl/eth_vlg_pkg.sv | 22 ++
 rtl/eth_vlg_rr_arb.sv | 48 ++++
 rtl/eth_vlg_tx_sched.sv | 152 +++++++++++++++
 tb/tb_eth_vlg_tx_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_vlg_pkg.sv
// Shared Ethernet TX/RX types.
//   stream_t       : byte-wide frame stream beat (data + framing flags)
//   tx_sched_fsm_t : states of the TX round-robin scheduler
package eth_vlg_pkg;

  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;

  // Literals carry an ST_ prefix so they never collide with the GAP parameter.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } tx_sched_fsm_t;

endpackage

// File: rtl/eth_vlg_rr_arb.sv
// Combinational rotate-priority arbiter: picks the first set request bit at or
// above ptr, wrapping to the lowest set bit below ptr.
//   req   in  N        request vector
//   ptr   in  clog2(N) highest-priority position
//   grant out N        one-hot grant (all zero when req==0)
//   idx   out clog2(N) index of the granted bit
//   any   out 1        at least one request present
module eth_vlg_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;
  logic          w_hi_found;

  // Scan downwards so the last hit written is the lowest index of each group.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    any        = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = IW'(i);
        any      = 1'b1;
        if (IW'(i) >= ptr) begin
          w_hi_idx   = IW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/eth_vlg_tx_sched.sv
// Round-robin scheduler sharing one TX MAC stream among N protocol sources.
// Grants one source per frame, routes the MAC handshake back to it, muxes its
// meta/stream toward the MAC, bounds the grant with a watchdog and inserts an
// idle gap after each frame.
//   clk, rst             clock, synchronous active-high reset
//   rdy[N]               source has a frame ready
//   req/acc/done[N]      MAC handshake routed to the granted source (1-cycle latency)
//   meta[N][W], strm[N]  per-source metadata and stream
//   rdy_mux              frame ready toward the MAC
//   req/acc/done_mux     MAC handshake inputs
//   meta_mux, strm_mux   registered meta/stream of the granted source
//   grant_id             granted source index (valid while busy)
//   busy                 high in ARB/ACTIVE/GAP
//   tmo                  1-cycle pulse on watchdog abort
//
// state     | meaning
// ST_IDLE   | no grant, waiting for any rdy
// ST_ARB    | pick next source by rotate priority, latch grant
// ST_ACTIVE | frame in progress for grant_id, watchdog running
// ST_GAP    | GAP idle cycles before the next arbitration
module eth_vlg_tx_sched
  import eth_vlg_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int GAP     = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          rdy,
  output logic [N-1:0]          req,
  output logic [N-1:0]          acc,
  output logic [N-1:0]          done,
  input  logic [N-1:0][W-1:0]   meta,
  input  stream_t [N-1:0]       strm,
  output logic                  rdy_mux,
  input  logic                  req_mux,
  input  logic                  acc_mux,
  input  logic                  done_mux,
  output logic [W-1:0]          meta_mux,
  output stream_t               strm_mux,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  busy,
  output logic                  tmo
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  tx_sched_fsm_t r_state;
  tx_sched_fsm_t w_state_nxt;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_gid;
  logic [N-1:0]  r_gsel;
  logic [CW-1:0] r_wdog;
  logic [GW-1:0] r_gap;
  logic          r_commit;

  logic [N-1:0]  w_arb_grant;
  logic [IW-1:0] w_arb_idx;
  logic          w_arb_any;
  logic [N-1:0]  w_sel;
  logic          w_active;
  logic          w_timeout;
  logic          w_withdraw;
  logic          w_release;

  eth_vlg_rr_arb #(.N(N)) u_arb (
    .req   (rdy),
    .ptr   (r_ptr),
    .grant (w_arb_grant),
    .idx   (w_arb_idx),
    .any   (w_arb_any)
  );

  always_comb begin
    w_active   = (r_state == ST_ACTIVE);
    w_sel      = w_active ? r_gsel : '0;
    w_timeout  = w_active && (r_wdog == CW'(TIMEOUT - 1));
    // A req_mux in the same cycle as the rdy drop already commits the frame.
    w_withdraw = w_active && !r_commit && !req_mux && ((rdy & r_gsel) == '0);
    w_release  = w_active && (done_mux || w_timeout || w_withdraw);
    // done_mux on the watchdog cycle is a normal completion.
    tmo        = w_timeout && !done_mux;
    busy       = (r_state != ST_IDLE);
    grant_id   = r_gid;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (rdy != '0) w_state_nxt = ST_ARB;
      // Sources may drop rdy during ARB; with nothing left to grant, fall back.
      ST_ARB:    w_state_nxt = w_arb_any ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: if (w_release) w_state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:    if (r_gap == GW'(GAP - 1)) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gid    <= '0;
      r_gsel   <= '0;
      r_wdog   <= '0;
      r_gap    <= '0;
      r_commit <= 1'b0;
      rdy_mux  <= 1'b0;
      req      <= '0;
      acc      <= '0;
      done     <= '0;
      meta_mux <= '0;
      strm_mux <= '0;
    end else begin
      if (r_state == ST_ARB && w_arb_any) begin
        r_gid    <= w_arb_idx;
        r_gsel   <= w_arb_grant;
        r_wdog   <= '0;
        r_commit <= 1'b0;
      end else if (w_active) begin
        if (r_wdog != CW'(TIMEOUT - 1)) r_wdog <= r_wdog + 1'b1;
        if (req_mux) r_commit <= 1'b1;
      end

      if (w_release) r_ptr <= (r_gid == IW'(N - 1)) ? '0 : r_gid + IW'(1);

      if (r_state != ST_GAP)            r_gap <= '0;
      else if (r_gap != GW'(GAP - 1))   r_gap <= r_gap + 1'b1;

      rdy_mux <= (w_state_nxt == ST_ACTIVE);

      req  <= w_sel & {N{req_mux}};
      acc  <= w_sel & {N{acc_mux}};
      done <= w_sel & {N{done_mux}};

      if (w_active) begin
        meta_mux <= meta[r_gid];
        strm_mux <= strm[r_gid];
      end
    end
  end

endmodule

// File: tb/tb_eth_vlg_tx_sched.sv
module tb_eth_vlg_tx_sched;
  import eth_vlg_pkg::*;

  localparam int N = 4, W = 8, GAP = 12, TIMEOUT = 24;
  localparam int EV_GRANT = 0, EV_REQ = 1, EV_ACC = 2, EV_DONE = 3,
                 EV_TMO = 4, EV_REL = 5, EV_IDLE = 6;

  typedef struct {
    int kind;
    int val;
    int aux;
    int cyc;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        rdy = '0;
  logic [N-1:0]        req, acc, done;
  logic [N-1:0][W-1:0] meta;
  stream_t [N-1:0]     strm;
  logic                rdy_mux;
  logic                req_mux = 1'b0, acc_mux = 1'b0, done_mux = 1'b0;
  logic [W-1:0]        meta_mux;
  stream_t             strm_mux;
  logic [1:0]          grant_id;
  logic                busy, tmo;

  ev_t  q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic p_rdy = 1'b0, p_busy = 1'b0;

  eth_vlg_tx_sched #(.N(N), .W(W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req(req), .acc(acc), .done(done),
    .meta(meta), .strm(strm), .rdy_mux(rdy_mux), .req_mux(req_mux),
    .acc_mux(acc_mux), .done_mux(done_mux), .meta_mux(meta_mux),
    .strm_mux(strm_mux), .grant_id(grant_id), .busy(busy), .tmo(tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_GRANT: return "GRANT";
      EV_REQ:   return "REQ";
      EV_ACC:   return "ACC";
      EV_DONE:  return "DONE";
      EV_TMO:   return "TMO";
      EV_REL:   return "RDYMUX_FALL";
      EV_IDLE:  return "BUSY_FALL";
      default:  return "?";
    endcase
  endfunction

  // Expected meta/stream byte pair presented by source g.
  function automatic int exp_aux(input int g);
    return ((8'h10 + g) << 8) | (8'hA0 + g);
  endfunction

  task automatic push(input int k, input int v, input int a, input int c);
    ev_t e;
    e.kind = k; e.val = v; e.aux = a; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic see(input int k, input int v, input int a);
    ev_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s: val=%0h aux=%0h at cycle %0d, nothing expected", kname(k), v, a, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v || e.aux != a || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event %s: got %s val=%0h aux=%0h cycle=%0d, expected %s val=%0h aux=%0h cycle=%0d",
                 kname(e.kind), kname(k), v, a, cyc, kname(e.kind), e.val, e.aux, e.cyc);
      end
    end
  endtask

  // Monitor: sample mid-cycle, report events in a fixed intra-cycle order.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdy_mux && !p_rdy) see(EV_GRANT, int'(grant_id), 0);
      if (req  != '0)        see(EV_REQ,  int'(req), 0);
      if (acc  != '0)        see(EV_ACC,  int'(acc), 0);
      if (done != '0)        see(EV_DONE, int'(done), int'({strm_mux.dat, meta_mux}));
      if (tmo)               see(EV_TMO,  int'(grant_id), 0);
      if (!rdy_mux && p_rdy) see(EV_REL,  0, 0);
      if (!busy && p_busy)   see(EV_IDLE, 0, 0);
    end
    p_rdy  = rdy_mux;
    p_busy = busy;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rdy_mux"},  {31'd0, rdy_mux}, 32'd0);
    check({tag, " busy/tmo"}, {30'd0, busy, tmo}, 32'd0);
    check({tag, " grant_id"}, {30'd0, grant_id}, 32'd0);
    check({tag, " req/acc/done"}, {20'd0, req, acc, done}, 32'd0);
    check({tag, " meta/strm"}, {12'd0, meta_mux, strm_mux}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    goto(cyc + 2);
    rst = 1'b0;
    check_idle_outputs("reset");
  endtask

  // One granted frame whose first ACTIVE cycle is a; offsets relative to a.
  task automatic serve(input int a, input int gid, input int req_off, input int acc_off,
                       input int done_off, input int drop_off, input logic [N-1:0] rdy_after);
    push(EV_GRANT, gid, 0, a);
    push(EV_REQ, 1 << gid, 0, a + req_off + 1);
    push(EV_ACC, 1 << gid, 0, a + acc_off + 1);
    push(EV_DONE, 1 << gid, exp_aux(gid), a + done_off + 1);
    push(EV_REL, 0, 0, a + done_off + 1);
    push(EV_IDLE, 0, 0, a + done_off + 1 + GAP);
    for (int k = 0; k <= done_off; k++) begin
      goto(a + k);
      req_mux  = (k == req_off);
      acc_mux  = (k == acc_off);
      done_mux = (k == done_off);
      if (k == drop_off) rdy = rdy_after;
    end
    goto(a + done_off + 1);
    req_mux = 1'b0; acc_mux = 1'b0; done_mux = 1'b0;
  endtask

  initial begin
    int t, a;
    for (int i = 0; i < N; i++) begin
      meta[i] = 8'(8'hA0 + i);
      strm[i] = '{dat: 8'(8'h10 + i), val: 1'b1, sof: 1'b0, eof: 1'b0, err: 1'b0};
    end

    do_reset();

    // Single source: req at T+3, done at T+20, stray handshake during GAP.
    t = cyc + 1; goto(t); rdy = 4'b0001;
    serve(t + 2, 0, 1, 10, 18, 18, 4'b0000);
    goto(t + 25); req_mux = 1'b1; acc_mux = 1'b1; done_mux = 1'b1;
    goto(t + 26); req_mux = 1'b0; acc_mux = 1'b0; done_mux = 1'b0;
    goto(t + 34);

    // Fairness: all ready, five short frames -> 0,1,2,3,0.
    do_reset();
    t = cyc + 1; goto(t); rdy = 4'b1111;
    a = t + 2;
    for (int f = 0; f < 5; f++) begin
      serve(a, f % 4, 1, 2, 3, (f == 4) ? 3 : -1, 4'b0000);
      a = a + 3 + 1 + GAP + 2;
    end
    goto(a);

    // Withdraw src2 before any req; src3 then granted, and its later rdy drop is ignored.
    do_reset();
    t = cyc + 1; goto(t); rdy = 4'b1100;
    a = t + 2;
    push(EV_GRANT, 2, 0, a);
    push(EV_REL, 0, 0, a + 1);
    push(EV_IDLE, 0, 0, a + 1 + GAP);
    goto(a); rdy = 4'b1000;
    serve(a + GAP + 3, 3, 1, 3, 6, 4, 4'b0000);
    goto(a + GAP + 3 + 6 + GAP + 2);

    // Watchdog abort on ACTIVE cycle TIMEOUT, pointer advances past src0.
    do_reset();
    t = cyc + 1; goto(t); rdy = 4'b0001;
    a = t + 2;
    push(EV_GRANT, 0, 0, a);
    push(EV_TMO, 0, 0, a + TIMEOUT - 1);
    push(EV_REL, 0, 0, a + TIMEOUT);
    push(EV_IDLE, 0, 0, a + TIMEOUT + GAP);
    goto(a + TIMEOUT); rdy = 4'b0011;
    serve(a + TIMEOUT + GAP + 2, 1, 1, 2, 3, 3, 4'b0000);
    goto(a + TIMEOUT + GAP + 2 + 3 + GAP + 2);

    // done_mux exactly on the watchdog cycle: done wins, no tmo.
    t = cyc + 1; goto(t); rdy = 4'b0100;
    a = t + 2;
    serve(a, 2, 1, 5, TIMEOUT - 1, TIMEOUT - 1, 4'b0000);
    goto(a + TIMEOUT - 1 + GAP + 2);

    // Reset mid-ACTIVE on src3: outputs clear, next arbitration starts at src0.
    t = cyc + 1; goto(t); rdy = 4'b1111;
    a = t + 2;
    push(EV_GRANT, 3, 0, a);
    push(EV_REQ, 4'b1000, 0, a + 2);
    push(EV_REL, 0, 0, a + 4);
    push(EV_IDLE, 0, 0, a + 4);
    goto(a + 1); req_mux = 1'b1;
    goto(a + 2); req_mux = 1'b0;
    goto(a + 3); rst = 1'b1;
    goto(a + 4); rst = 1'b0;
    check_idle_outputs("mid-frame reset");
    serve(a + 6, 0, 1, 2, 3, 3, 4'b0000);
    goto(a + 6 + 3 + GAP + 2);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("pending expected events", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
